scan_sequencer: RTL and testbench

Sequencer that produces the 3-bit channel index consumed directly by the team's 3-to-8 one-hot decoder (`sel` drives the decoder's select input). It steps through the enabled channels in ascending order with a programmable dwell per channel. Scans run either once (one-shot) or continuously, and disabled channels are skipped. It gives the decoder a clean, glitch-free, registered select stream, with status pulses for the surrounding control logic.

---
 rtl/scan_pkg.sv | 12 +
 rtl/next_chan_find.sv | 32 +++
 rtl/scan_sequencer.sv | 156 +++++++++++++++
 tb/tb_scan_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants and state type for the channel scan sequencer
package scan_pkg;

  localparam int NCH   = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/next_chan_find.sv
// rtl/next_chan_find.sv - combinational finder for the next enabled channel index
//
// Ports:
//   mask  - channel enables, bit i = channel i
//   cur   - current channel index
//   first - 1: search from channel 0 inclusive; 0: search strictly above cur
//   idx   - lowest matching enabled index (0 when none)
//   found - a matching enabled channel exists
module next_chan_find
  import scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [IDX_W-1:0] cur,
  input  logic             first,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Descending scan so the last hit written is the lowest qualifying index.
  // Wrap is reported through found=0, never through 3-bit rollover of cur.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (IDX_W'(i) > cur))) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - registered channel-select sequencer feeding a 3-to-8 decoder
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - 1-cycle scan request, honoured in IDLE only
//   stop       - abort, highest priority
//   hold       - freezes the dwell counter in RUN
//   mode       - 0 one-shot, 1 continuous (latched at start)
//   ch_mask    - channel enables (latched at start)
//   dwell      - per-channel hold cycles minus one (latched at start)
//   sel        - registered channel index
//   sel_valid  - sel is a live scan channel
//   busy       - sequencer in RUN
//   step       - pulse when sel takes a new channel
//   done       - pulse at the end of each completed pass
//   err        - pulse when start is rejected for an empty mask
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               mode,
  input  logic [NCH-1:0]     ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [IDX_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               step,
  output logic               done,
  output logic               err
);

  scan_state_t        state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [NCH-1:0]     mask_q, mask_n;
  logic               mode_q, mode_n;
  logic [IDX_W-1:0]   sel_n;
  logic               valid_n, step_n, done_n, err_n;

  logic [IDX_W-1:0]   nxt_idx, low_idx;
  logic               nxt_found, low_found;
  logic [NCH-1:0]     low_mask;

  // In IDLE the lowest channel comes from the live mask being latched this
  // cycle; in RUN it comes from the latched mask for continuous wrap.
  assign low_mask = (state == IDLE) ? ch_mask : mask_q;

  next_chan_find u_next (
    .mask  (mask_q),
    .cur   (sel),
    .first (1'b0),
    .idx   (nxt_idx),
    .found (nxt_found)
  );

  next_chan_find u_low (
    .mask  (low_mask),
    .cur   (sel),
    .first (1'b1),
    .idx   (low_idx),
    .found (low_found)
  );

  // busy is the state flop itself, so it stays registered.
  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dwell_q   <= '0;
      mask_q    <= '0;
      mode_q    <= 1'b0;
      sel       <= '0;
      sel_valid <= 1'b0;
      step      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dwell_q   <= dwell_n;
      mask_q    <= mask_n;
      mode_q    <= mode_n;
      sel       <= sel_n;
      sel_valid <= valid_n;
      step      <= step_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dwell_n = dwell_q;
    mask_n  = mask_q;
    mode_n  = mode_q;
    sel_n   = sel;
    valid_n = sel_valid;
    step_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          dwell_n = dwell;
          mask_n  = ch_mask;
          mode_n  = mode;
          if (!low_found) begin
            err_n = 1'b1;
          end else begin
            state_n = RUN;
            sel_n   = low_idx;
            valid_n = 1'b1;
            step_n  = 1'b1;
            cnt_n   = '0;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else if (hold) begin
          // counter and sel frozen
        end else if (cnt < dwell_q) begin
          cnt_n = cnt + DWELL_W'(1);
        end else if (nxt_found) begin
          sel_n  = nxt_idx;
          step_n = 1'b1;
          cnt_n  = '0;
        end else begin
          done_n = 1'b1;
          if (mode_q) begin
            sel_n  = low_idx;
            step_n = 1'b1;
            cnt_n  = '0;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed scoreboard bench for scan_sequencer
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic [2:0] sel;
  logic       sel_valid, busy, step, done, err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // expected vector {sel, sel_valid, busy, step, done, err}
  logic [7:0] q[$];

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .mode      (mode),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .step      (step),
    .done      (done),
    .err       (err)
  );

  task automatic push(input logic [2:0] s, input logic v, input logic b,
                      input logic st, input logic d, input logic e);
    q.push_back({s, v, b, st, d, e});
  endtask

  task automatic push_idle(input logic [2:0] s);
    push(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One channel shown for n cycles; its first cycle carries step (and done on wrap).
  task automatic push_chan(input logic [2:0] c, input int n, input logic d);
    push(c, 1'b1, 1'b1, 1'b1, d, 1'b0);
    for (int k = 1; k < n; k++) push(c, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_pass(input logic [7:0] m, input int dw, input logic wrap_done);
    logic first_ch;
    first_ch = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        push_chan(3'(i), dw + 1, wrap_done && first_ch);
        first_ch = 1'b0;
      end
    end
  endtask

  task automatic compare_now(input string tag);
    logic [7:0] obs, exp_v;
    obs = {sel, sel_valid, busy, step, done, err};
    checks++;
    if (q.size() == 0) begin
      fails++;
      $error("FAIL %s no expected entry, obs=%b", tag, obs);
    end else begin
      exp_v = q.pop_front();
      assert (obs === exp_v) passes++;
      else begin
        fails++;
        $error("FAIL %s obs=%b exp=%b (sel,valid,busy,step,done,err)", tag, obs, exp_v);
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    compare_now(tag);
    start = 1'b0;
  endtask

  task automatic run_n(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  initial begin
    // reset state
    #2;
    push_idle(3'd0);
    compare_now("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #3;
    push_idle(3'd0);
    compare_now("post_reset");

    // full mask, dwell 0, one-shot
    ch_mask = 8'hFF; dwell = 8'd0; mode = 1'b0;
    push_pass(8'hFF, 0, 1'b0);
    push(3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_idle(3'd7);
    start = 1'b1;
    run_n("oneshot_ff", 10);

    // mask 0xA5, dwell 2, continuous, two passes then stop on ch7 terminal cycle
    ch_mask = 8'hA5; dwell = 8'd2; mode = 1'b1;
    push_pass(8'hA5, 2, 1'b0);
    push_pass(8'hA5, 2, 1'b1);
    start = 1'b1;
    run_n("cont_a5", 24);
    stop = 1'b1;
    push_idle(3'd7);
    cycle("stop_terminal");
    start = 1'b1;
    push_idle(3'd7);
    cycle("stop_start_idle");
    stop = 1'b0;
    push_idle(3'd7);
    cycle("idle_after_stop");

    // empty mask rejected
    ch_mask = 8'h00; mode = 1'b0;
    push(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(3'd7);
    start = 1'b1;
    run_n("empty_mask", 2);

    // mask 0x0F, dwell 3, hold 5 cycles on channel 1
    ch_mask = 8'h0F; dwell = 8'd3; mode = 1'b0;
    push_chan(3'd0, 4, 1'b0);
    push_chan(3'd1, 9, 1'b0);
    push_chan(3'd2, 4, 1'b0);
    push_chan(3'd3, 4, 1'b0);
    push(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_idle(3'd3);
    start = 1'b1;
    run_n("hold_pre", 5);
    hold = 1'b1;
    run_n("hold_on", 5);
    hold = 1'b0;
    run_n("hold_post", 13);

    // asynchronous reset mid-run, then a fresh start
    ch_mask = 8'h3C; dwell = 8'd1; mode = 1'b1;
    push_chan(3'd2, 2, 1'b0);
    push(3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    run_n("pre_reset_run", 3);
    #3;
    rst_n = 1'b0;
    #1;
    push_idle(3'd0);
    compare_now("async_reset");
    #2;
    rst_n = 1'b1;
    push_chan(3'd2, 2, 1'b0);
    push_chan(3'd3, 2, 1'b0);
    start = 1'b1;
    run_n("restart", 4);

    if (q.size() != 0) begin
      checks++;
      fails++;
      $error("FAIL leftover_expected count=%0d required=0", q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
